// File: rtl/toggle_activity_monitor_if.sv
// Bus bundle for the toggle activity monitor: the stimulus/control inputs
// and the measurement results, seen from the driver (master) and from the
// monitor itself (slave).
interface toggle_activity_monitor_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             din;
    logic             start;
    logic [WIN_W-1:0] window;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [WIN_W-1:0] hi_cnt;
    logic             ovf;

    modport master (
        output din, start, window, abort,
        input  busy, done, rise_cnt, fall_cnt, hi_cnt, ovf
    );

    modport slave (
        input  din, start, window, abort,
        output busy, done, rise_cnt, fall_cnt, hi_cnt, ovf
    );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Toggle activity monitor: samples a (possibly asynchronous) cell output
// through a two-flop synchronizer and, over a window of WINDOW sample
// cycles, counts rising edges, falling edges and cycles spent high.
// Edge counters saturate and raise a sticky overflow flag.
module toggle_activity_monitor #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    toggle_activity_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    state_t           state;
    state_t           state_nxt;

    logic             sync1;
    logic             sync2;
    logic             sample;
    logic             prev;
    logic [WIN_W-1:0] remaining;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [WIN_W-1:0] hi_cnt;
    logic             ovf;

    logic             accept;
    logic             arming;
    logic             measuring;
    logic             rise_seen;
    logic             fall_seen;

    // Resynchronize DIN into the clk domain before anything looks at it.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source (sync2 gets the old sync1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.din;
            sync2 <= sync1;
        end
    end

    assign sample = sync2;

    // A START in IDLE always starts a run; ABORT only matters while busy.
    assign accept    = (state == S_IDLE) && bus.start;
    assign arming    = (state == S_ARM) && !bus.abort;
    assign measuring = (state == S_MEASURE) && !bus.abort;
    assign rise_seen = !prev && sample;
    assign fall_seen = prev && !sample;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one ARM cycle, WINDOW MEASURE cycles, one DONE cycle.
    // NOTE: state_nxt gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.window != '0) ? S_ARM : S_DONE;
                end
            end
            S_ARM: begin
                state_nxt = bus.abort ? S_IDLE : S_MEASURE;
            end
            S_MEASURE: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (remaining == WIN_ONE) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Measurement datapath: clear on accept, load the reference sample in
    // ARM, count and step the window in MEASURE, hold everything otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= 1'b0;
            remaining <= '0;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            hi_cnt    <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            remaining <= bus.window;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            hi_cnt    <= '0;
            ovf       <= 1'b0;
        end else if (arming) begin
            prev <= sample;
        end else if (measuring) begin
            // Edge counters stick at all-ones; a further edge flags overflow.
            if (rise_seen) begin
                if (&rise_cnt) begin
                    ovf <= 1'b1;
                end else begin
                    rise_cnt <= rise_cnt + CNT_ONE;
                end
            end
            if (fall_seen) begin
                if (&fall_cnt) begin
                    ovf <= 1'b1;
                end else begin
                    fall_cnt <= fall_cnt + CNT_ONE;
                end
            end
            // Bounded by WINDOW, so this count cannot wrap.
            if (sample) begin
                hi_cnt <= hi_cnt + WIN_ONE;
            end
            prev      <= sample;
            remaining <= remaining - WIN_ONE;
        end
    end

    // Status decoded straight from the state so reset clears it at once.
    assign bus.busy     = (state == S_ARM) || (state == S_MEASURE);
    assign bus.done     = (state == S_DONE);
    assign bus.rise_cnt = rise_cnt;
    assign bus.fall_cnt = fall_cnt;
    assign bus.hi_cnt   = hi_cnt;
    assign bus.ovf      = ovf;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Self-checking bench for toggle_activity_monitor. A timeline model records
// DIN at every clock edge and derives the expected outputs from the window
// rules; a compare process checks every cycle, and directed runs pin the
// model with hand-computed results.
module tb_toggle_activity_monitor;

    localparam int CNT_W = 4;
    localparam int WIN_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int HMAX  = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;

    toggle_activity_monitor_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    toggle_activity_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model. hist[k] is the DIN value captured at edge k (0 if the
    // synchronizer was cleared). The sample used at edge j is hist[j-2].
    // A run accepted at edge k0 with window w uses the reference sample at
    // edge k0+1 and counts edges k0+2 .. k0+w+1 (cut short by an abort).
    // ------------------------------------------------------------------
    bit hist [HMAX];
    int e          = -1;
    int k0         = -1;
    int w0         = 0;
    int abort_edge = -1;
    int free_edge  = 0;

    function automatic bit samp(input int j);
        int idx;
        idx = j - 2;
        if (idx >= 0 && idx < HMAX) return hist[idx];
        return 1'b0;
    endfunction

    function automatic void model_outputs(input int m, output bit b, output bit d,
                                          output int r, output int f, output int h,
                                          output bit o);
        int last;
        bit p;
        bit s;
        b = 1'b0; d = 1'b0; r = 0; f = 0; h = 0; o = 1'b0;
        if (k0 < 0) return;
        if (w0 == 0) begin
            d = (m == k0);
            return;
        end
        b = (m >= k0) && (m <= k0 + w0) && (abort_edge < 0 || m < abort_edge);
        d = (abort_edge < 0) && (m == k0 + w0 + 1);
        last = (abort_edge >= 0) ? abort_edge - 1 : k0 + w0 + 1;
        if (m < last) last = m;
        p = samp(k0 + 1);
        for (int j = k0 + 2; j <= last; j++) begin
            s = samp(j);
            if (s && !p) r++;
            if (!s && p) f++;
            if (s) h++;
            p = s;
        end
        o = (r > CMAX) || (f > CMAX);
        if (r > CMAX) r = CMAX;
        if (f > CMAX) f = CMAX;
    endfunction

    initial begin : model
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                if (clk) begin
                    e++;
                    if (e >= 0 && e < HMAX) hist[e] = 1'b0;
                end else begin
                    if (e >= 0 && e < HMAX) hist[e] = 1'b0;
                    if (e >= 1 && e <= HMAX) hist[e-1] = 1'b0;
                end
                k0         = -1;
                abort_edge = -1;
                free_edge  = e + 1;
            end else begin
                e++;
                if (e < HMAX) hist[e] = bus.din;
                if (e >= free_edge && bus.start) begin
                    k0         = e;
                    w0         = int'(bus.window);
                    abort_edge = -1;
                    free_edge  = (w0 == 0) ? e + 2 : e + w0 + 3;
                end else if (k0 >= 0 && w0 > 0 && abort_edge < 0 && bus.abort &&
                             e >= k0 + 1 && e <= k0 + w0 + 1) begin
                    abort_edge = e;
                    free_edge  = e + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin : compare
        bit xb, xd, xo;
        int xr, xf, xh;
        forever begin
            @(negedge clk);
            model_outputs(e, xb, xd, xr, xf, xh, xo);
            check("cyc busy", bus.busy, xb);
            check("cyc done", bus.done, xd);
            check("cyc rise_cnt", bus.rise_cnt, xr);
            check("cyc fall_cnt", bus.fall_cnt, xf);
            check("cyc hi_cnt", bus.hi_cnt, xh);
            check("cyc ovf", bus.ovf, xo);
        end
    end

    // ------------------------------------------------------------------
    // DIN pattern generator: 0 low, 1 high, 2 square period 4, 3 toggle.
    // ------------------------------------------------------------------
    int din_mode = 0;
    int ph;

    initial begin : din_gen
        bus.din = 1'b0;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (din_mode)
                0:       bus.din = 1'b0;
                1:       bus.din = 1'b1;
                2: begin
                    ph = (ph + 1) % 4;
                    bus.din = (ph < 2);
                end
                default: bus.din = ~bus.din;
            endcase
        end
    end

    // Called at posedge+1. Starts a window, waits (bounded) for DONE and
    // checks latency and final counts. With hold set, START stays high
    // through the DONE cycle and must not be taken again.
    task automatic run_window(input string tag, input int w, input bit hold,
                              input int exp_lat, input int er, input int ef,
                              input int eh, input int eo);
        int lat;
        bit busy_seen;
        lat       = -1;
        busy_seen = 1'b0;
        bus.start  = 1'b1;
        bus.window = WIN_W'(w);
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        for (int n = 1; n <= w + 20; n++) begin
            @(negedge clk);
            if (bus.busy) busy_seen = 1'b1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        check({tag, " done latency"}, lat, exp_lat);
        check({tag, " rise_cnt"}, bus.rise_cnt, er);
        check({tag, " fall_cnt"}, bus.fall_cnt, ef);
        check({tag, " hi_cnt"}, bus.hi_cnt, eh);
        check({tag, " ovf"}, bus.ovf, eo);
        check({tag, " busy seen"}, busy_seen, (w != 0));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, " idle after done"}, bus.busy, 0);
        check({tag, " hi_cnt held"}, bus.hi_cnt, eh);
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with DIN held high. ABORT is sampled at edge
    // k0+at_n, so at_n-2 samples (never negative) are counted.
    task automatic run_abort(input string tag, input int w, input int at_n, input int eh);
        bit done_seen;
        done_seen  = 1'b0;
        bus.start  = 1'b1;
        bus.window = WIN_W'(w);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, " busy after start"}, bus.busy, 1);
        check({tag, " ovf cleared"}, bus.ovf, 0);
        for (int i = 1; i < at_n; i++) begin
            @(posedge clk);
            #1;
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check({tag, " busy after abort"}, bus.busy, 0);
        check({tag, " done after abort"}, bus.done, 0);
        check({tag, " hi_cnt"}, bus.hi_cnt, eh);
        check({tag, " rise_cnt"}, bus.rise_cnt, 0);
        for (int n = 0; n < w + 4; n++) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        check({tag, " no done pulse"}, done_seen, 0);
        check({tag, " hi_cnt frozen"}, bus.hi_cnt, eh);
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int mode);
        din_mode = mode;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.window = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset rise_cnt", bus.rise_cnt, 0);
        check("reset fall_cnt", bus.fall_cnt, 0);
        check("reset hi_cnt", bus.hi_cnt, 0);
        check("reset ovf", bus.ovf, 0);
        rst = 1'b0;

        settle(2);
        run_window("square w8", 8, 1'b1, 10, 2, 2, 4, 0);
        settle(1);
        run_window("high w5", 5, 1'b0, 7, 0, 0, 5, 0);
        settle(3);
        run_window("toggle w64", 64, 1'b0, 66, CMAX, CMAX, 32, 1);
        settle(1);
        run_abort("abort meas3", 10, 4, 2);
        run_window("after abort", 3, 1'b0, 5, 0, 0, 3, 0);
        run_abort("abort last", 4, 5, 3);
        run_abort("abort arm", 6, 1, 0);
        run_window("pre zero", 4, 1'b0, 6, 0, 0, 4, 0);
        bus.abort = 1'b1;
        run_window("zero window", 0, 1'b1, 1, 0, 0, 0, 0);
        bus.abort = 1'b0;

        // Asynchronous reset in the middle of a measurement.
        bus.start  = 1'b1;
        bus.window = WIN_W'(20);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #7;
        rst = 1'b1;
        #1;
        check("async rst busy", bus.busy, 0);
        check("async rst done", bus.done, 0);
        check("async rst rise_cnt", bus.rise_cnt, 0);
        check("async rst fall_cnt", bus.fall_cnt, 0);
        check("async rst hi_cnt", bus.hi_cnt, 0);
        check("async rst ovf", bus.ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_window("post reset", 3, 1'b0, 5, 1, 0, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/toggle_activity_monitor.md
TOGGLE_ACTIVITY_MONITOR -- requirements
Module: toggle_activity_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of RISE_CNT and FALL_CNT.
REQ-002 SHALL have parameter WIN_W, default 16: width of WINDOW and HI_CNT.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port DIN, input, 1, the cell output under test (e.g. an OA222 Q pin); it may be asynchronous to CLK.
REQ-007 SHALL have port START, input, 1, a request to begin one measurement window.
REQ-008 SHALL have port WINDOW, input, WIN_W, the number of sample cycles to measure; it is captured when START is accepted.
REQ-009 SHALL have port ABORT, input, 1, which terminates an active measurement.
REQ-010 SHALL have port BUSY, output, 1, high while the state is ARM or MEASURE.
REQ-011 SHALL have port DONE, output, 1, a one-cycle pulse marking window completion.
REQ-012 SHALL have port RISE_CNT, output, CNT_W, the count of 0->1 transitions.
REQ-013 SHALL have port FALL_CNT, output, CNT_W, the count of 1->0 transitions.
REQ-014 SHALL have port HI_CNT, output, WIN_W, the count of sample cycles with DIN high.
REQ-015 SHALL have port OVF, output, 1, a sticky flag: set when RISE_CNT or FALL_CNT saturated.

Function
REQ-016 SHALL pass DIN through a 2-flop synchronizer; a DIN change before clock edge t is visible to the counters at edge t+2.
REQ-017 SHALL implement the states IDLE, ARM, MEASURE and DONE.
REQ-018 In IDLE, START=1 with WINDOW!=0 SHALL capture WINDOW into the remaining counter, clear RISE_CNT, FALL_CNT, HI_CNT and OVF, and move to ARM.
REQ-019 In IDLE, START=1 with WINDOW=0 SHALL clear the counts and OVF and move directly to DONE; BUSY stays 0.
REQ-020 ARM SHALL last exactly one cycle: it loads the reference sample (prev <= synchronized DIN), does no counting, and moves to MEASURE.
REQ-021 Each MEASURE cycle SHALL: increment RISE_CNT if prev=0 and sample=1; increment FALL_CNT if prev=1 and sample=0; increment HI_CNT if sample=1; update prev; decrement remaining.
REQ-022 MEASURE SHALL move to DONE on the cycle in which remaining equals 1, so exactly WINDOW samples are counted.
REQ-023 RISE_CNT and FALL_CNT SHALL saturate at all-ones; an increment attempted while a counter is saturated SHALL set OVF, and OVF SHALL hold until the next accepted START or reset.
REQ-024 HI_CNT SHALL NOT overflow, since it never exceeds WINDOW.
REQ-025 DONE SHALL be high for exactly the single cycle spent in the DONE state, after which the state returns to IDLE.
REQ-026 Result latency SHALL be fixed: START accepted at edge 0 gives ARM at cycle 1, MEASURE at cycles 2..WINDOW+1, and DONE at cycle WINDOW+2.
REQ-027 START SHALL be ignored in ARM, MEASURE and DONE, including the DONE cycle itself.
REQ-028 ABORT=1 in ARM or MEASURE SHALL return the state to IDLE on the next edge, with no DONE pulse and the partial counts held.
REQ-029 ABORT SHALL be ignored in IDLE and DONE.
REQ-030 If ABORT coincides with the last MEASURE cycle, ABORT SHALL win: no DONE, and the last sample is not counted.
REQ-031 RISE_CNT, FALL_CNT, HI_CNT and OVF SHALL hold their values in IDLE until the next accepted START.

Reset
REQ-032 RST=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, BUSY=0, DONE=0, RISE_CNT=0, FALL_CNT=0, HI_CNT=0, OVF=0, clear the synchronizer flops, prev and remaining to 0, and discard any measurement in progress.
REQ-033 After RST is released, the first START SHALL be accepted on the first rising CLK edge at which RST is low.

Verification
REQ-034 SHALL cover: DIN a square wave of period 4 (2 high, 2 low) settled before START, WINDOW=8 -> RISE_CNT=2, FALL_CNT=2, HI_CNT=4, OVF=0, and DONE at cycle 10 after START.
REQ-035 SHALL cover: DIN held at 1, WINDOW=5 -> RISE_CNT=0, FALL_CNT=0, HI_CNT=5, and DONE at cycle 7.
REQ-036 SHALL cover: CNT_W=4, DIN toggling every cycle, WINDOW=64 -> RISE_CNT=15, FALL_CNT=15, OVF=1, HI_CNT=32.
REQ-037 SHALL cover: ABORT asserted in the 3rd MEASURE cycle -> BUSY=0 on the next cycle, no DONE pulse, counts frozen, and a following START accepted.
REQ-038 SHALL cover: START with WINDOW=0 -> DONE pulse on the next cycle, all counts 0, BUSY never 1.
REQ-039 SHALL cover: RST pulsed mid-MEASURE asynchronously between clock edges -> all outputs 0 immediately, and START accepted after release.
